// File: rtl/pps_gen_pkg.sv
// Shared types and helpers for the PPS generator: FSM state encoding, default
// counter width and the clamped effective-period calculation.
package pps_gen_pkg;

    localparam int unsigned CNT_W_DEF = 32;
    // Wide working width for period arithmetic; supports CNT_W up to 63.
    localparam int unsigned PEFF_W    = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StAlign = 2'd2
    } state_e;

    // Effective period (cycles-1) = period + signed corr, clamped to [1, pmax].
    // A result below 1 would give a second shorter than two cycles.
    function automatic logic [PEFF_W-1:0] calc_peff(
        input logic [PEFF_W-1:0] period,
        input logic [PEFF_W-1:0] corr,
        input logic [PEFF_W-1:0] pmax
    );
        logic signed [PEFF_W:0] sum;
        sum = $signed({1'b0, period}) + $signed({corr[PEFF_W-1], corr});
        if (sum[PEFF_W] || (sum == '0)) begin
            return PEFF_W'(1);
        end else if (sum[PEFF_W-1:0] > pmax) begin
            return pmax;
        end else begin
            return sum[PEFF_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pps_gen_edge.sv
// Rising-edge detector for an already-synchronised input. The previous sample
// is registered; a synchronous clear forces the history high so an input that
// is already high is not reported as a fresh edge.
module pps_gen_edge (
    input  logic clk,
    input  logic resetn,
    input  logic i_clr,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    // Track the previous input sample; clear re-arms the detector.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev <= 1'b1;
        end else if (i_clr) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev & ~i_clr;

endmodule

// File: rtl/pps_gen.sv
// Programmable PPS generator. Emits pps_out and a one-cycle fix_pulse at each
// second start, supports a one-shot signed period correction and alignment to
// an external pps_in edge with timeout.
// Optional: define PPS_GEN_SECONDS_EN to add the 32-bit sec_cnt output.
module pps_gen
    import pps_gen_pkg::*;
#(
    parameter int unsigned       CNT_W         = CNT_W_DEF,
    parameter logic [CNT_W-1:0]  PERIOD_DEF    = CNT_W'(99_999_999),
    parameter int unsigned       ALIGN_TMO_MUL = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] corr,
    input  logic             corr_stb,
    input  logic             align_req,
    input  logic             pps_in,
    output logic             pps_out,
    output logic             fix_pulse,
    output logic             align_tmo,
    output logic [1:0]       state
`ifdef PPS_GEN_SECONDS_EN
    ,
    output logic [31:0]      sec_cnt
`endif
);

    // Timeout counter width leaves headroom for the multiplier.
    localparam int unsigned TW = CNT_W + 8;

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [CNT_W-1:0] r_peff;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_corr;
    logic             r_corr_pend;
    logic [TW-1:0]    r_acnt, w_acnt_d;
    logic             r_pps, w_pps_d;
    logic             r_fix, w_fix_d;
    logic             r_tmo, w_tmo_d;

    logic             w_start;
    logic             w_align_ok;
    logic             w_edge_clr;
    logic             w_rise;
    logic [TW-1:0]    w_tmo_lim;
    logic [CNT_W-1:0] w_peff_new;
    logic [PEFF_W-1:0] w_period_x;
    logic [PEFF_W-1:0] w_corr_x;
    logic [PEFF_W-1:0] w_pmax_x;

    pps_gen_edge u_edge (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (w_edge_clr),
        .i_d    (pps_in),
        .o_rise (w_rise)
    );

    assign w_period_x = {{(PEFF_W-CNT_W){1'b0}}, period};
    assign w_corr_x   = r_corr_pend ? {{(PEFF_W-CNT_W){r_corr[CNT_W-1]}}, r_corr} : '0;
    assign w_pmax_x   = {{(PEFF_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
    assign w_peff_new = CNT_W'(calc_peff(w_period_x, w_corr_x, w_pmax_x));
    assign w_tmo_lim  = TW'(ALIGN_TMO_MUL) * (TW'(r_period) + TW'(1));

    // Next-state and registered-output decode; every entry into RUN at cnt=0
    // goes through w_start so all second starts behave the same way.
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_acnt_d   = r_acnt;
        w_pps_d    = 1'b0;
        w_fix_d    = 1'b0;
        w_tmo_d    = 1'b0;
        w_start    = 1'b0;
        w_align_ok = 1'b0;
        w_edge_clr = 1'b0;

        if (!enable) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_acnt_d  = '0;
        end else begin
            unique case (r_state)
                StIdle, StRun: begin
                    if (align_req) begin
                        w_state_d  = StAlign;
                        w_cnt_d    = '0;
                        w_acnt_d   = '0;
                        w_edge_clr = 1'b1;
                    end else if (r_state == StIdle || r_cnt >= r_peff) begin
                        w_start = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                        w_pps_d = (r_cnt + CNT_W'(1)) < r_width;
                    end
                end
                StAlign: begin
                    if (align_req) begin
                        // Restart the timeout window.
                        w_acnt_d   = '0;
                        w_edge_clr = 1'b1;
                    end else if (w_rise) begin
                        w_start    = 1'b1;
                        w_align_ok = 1'b1;
                    end else if (r_acnt + TW'(1) >= w_tmo_lim) begin
                        w_start = 1'b1;
                    end else begin
                        w_acnt_d = r_acnt + TW'(1);
                        // Timeout strobe lands on the last ALIGN cycle.
                        w_tmo_d  = (r_acnt + TW'(2)) == w_tmo_lim;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end

        if (w_start) begin
            w_state_d = StRun;
            w_cnt_d   = '0;
            w_fix_d   = 1'b1;
            w_pps_d   = (width != '0);
        end
    end

    // State, counters, outputs and per-second latched configuration.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_acnt      <= '0;
            r_pps       <= 1'b0;
            r_fix       <= 1'b0;
            r_tmo       <= 1'b0;
            r_peff      <= PERIOD_DEF;
            r_period    <= PERIOD_DEF;
            r_width     <= '0;
            r_corr      <= '0;
            r_corr_pend <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_acnt  <= w_acnt_d;
            r_pps   <= w_pps_d;
            r_fix   <= w_fix_d;
            r_tmo   <= w_tmo_d;
            if (w_start) begin
                r_period <= period;
                r_width  <= width;
                r_peff   <= w_peff_new;
            end
            // A new strobe wins over clearing the value applied this cycle.
            if (corr_stb) begin
                r_corr      <= corr;
                r_corr_pend <= 1'b1;
            end else if (w_start) begin
                r_corr_pend <= 1'b0;
            end
        end
    end

    assign pps_out   = r_pps;
    assign fix_pulse = r_fix;
    assign align_tmo = r_tmo;
    assign state     = r_state;

`ifdef PPS_GEN_SECONDS_EN
    logic [31:0] r_sec;

    // Seconds counter: restarts from zero on a successful alignment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sec <= '0;
        end else if (w_start) begin
            r_sec <= w_align_ok ? 32'd0 : r_sec + 32'd1;
        end
    end

    assign sec_cnt = r_sec;
`endif

endmodule
